uart_rx: RTL

//  UART receiver; the receive end of the link driven by the project's UART transmitter.

---
 rtl/uart_rx_pkg.sv | 14 +
 rtl/uart_rx_bit_timer.sv | 41 ++++
 rtl/uart_rx.sv | 126 ++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types for the UART receiver: bit alias and receive FSM state encoding.
package uart_rx_pkg;

   typedef logic bit_t;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP
   } rx_state_t;

endpackage

// File: rtl/uart_rx_bit_timer.sv
// Bit-period counter for the UART receiver: flags the mid-bit (half) and end-of-bit (full) counts.
module uart_rx_bit_timer
   import uart_rx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic clk,
   input  logic reset,
   input  bit_t restart,
   input  bit_t enable,
   output bit_t half_tick,
   output bit_t full_tick
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (restart) begin
         cnt_d = '0;
      end else if (enable) begin
         cnt_d = (cnt_q == FULL_CNT) ? '0 : cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign half_tick = enable & (cnt_q == HALF_CNT);
   assign full_tick = enable & (cnt_q == FULL_CNT);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronises rx, validates the start bit at mid-bit, samples data/parity/stop
// and reports a good byte with a valid strobe, or a frame/parity error pulse.
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434,
   parameter int DATA_WIDTH   = 8,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rx,
   input  logic                  clear_flag,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  rx_flag,
   output logic                  parity_error,
   output logic                  frame_error,
   output logic                  busy
);

   localparam int BW = $clog2(DATA_WIDTH + 1);
   localparam bit_t ODD = bit_t'(PARITY_ODD != 0);

   bit_t                  rx_meta_q, rx_s_q, rx_d_q;
   rx_state_t             state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, rx_data_q;
   logic [BW-1:0]         bitcnt_q;
   bit_t                  perr_q;
   bit_t                  rx_valid_q, rx_flag_q, parity_error_q, frame_error_q, busy_q;

   bit_t start_edge, restart, timer_en, half_tick, full_tick;
   bit_t shift_en, par_tick, stop_tick;

   uart_rx_bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .restart  (restart),
      .enable   (timer_en),
      .half_tick(half_tick),
      .full_tick(full_tick)
   );

   assign start_edge = rx_d_q & ~rx_s_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         RX_IDLE:   if (start_edge) state_d = RX_START;
         RX_START:  if (half_tick) state_d = rx_s_q ? RX_IDLE : RX_DATA;
         RX_DATA:   if (full_tick && bitcnt_q == BW'(DATA_WIDTH - 1))
                       state_d = (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
         RX_PARITY: if (full_tick) state_d = RX_STOP;
         RX_STOP:   if (full_tick) state_d = RX_IDLE;
         default:   state_d = RX_IDLE;
      endcase
   end

   // Timer is held at zero while idle and restarted on every state change so each state times from entry.
   assign timer_en  = (state_q != RX_IDLE);
   assign restart   = (state_d != state_q) || (state_q == RX_IDLE);
   assign shift_en  = (state_q == RX_DATA)   & full_tick;
   assign par_tick  = (state_q == RX_PARITY) & full_tick;
   assign stop_tick = (state_q == RX_STOP)   & full_tick;

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta_q      <= 1'b1;
         rx_s_q         <= 1'b1;
         rx_d_q         <= 1'b1;
         state_q        <= RX_IDLE;
         shift_q        <= '0;
         bitcnt_q       <= '0;
         perr_q         <= 1'b0;
         rx_data_q      <= '0;
         rx_valid_q     <= 1'b0;
         rx_flag_q      <= 1'b0;
         parity_error_q <= 1'b0;
         frame_error_q  <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         rx_meta_q      <= rx;
         rx_s_q         <= rx_meta_q;
         rx_d_q         <= rx_s_q;
         state_q        <= state_d;
         busy_q         <= (state_d != RX_IDLE);
         rx_valid_q     <= 1'b0;
         parity_error_q <= 1'b0;
         frame_error_q  <= 1'b0;
         // A set from the valid strobe takes priority over a simultaneous clear.
         rx_flag_q      <= rx_valid_q | (rx_flag_q & ~clear_flag);
         if (state_q == RX_IDLE) begin
            bitcnt_q <= '0;
            perr_q   <= 1'b0;
         end
         if (shift_en) begin
            shift_q  <= {rx_s_q, shift_q[DATA_WIDTH-1:1]};
            bitcnt_q <= bitcnt_q + BW'(1);
         end
         if (par_tick) begin
            perr_q <= (^shift_q) ^ rx_s_q ^ ODD;
         end
         if (stop_tick) begin
            if (!rx_s_q) begin
               frame_error_q <= 1'b1;
            end else if (perr_q) begin
               parity_error_q <= 1'b1;
            end else begin
               rx_data_q  <= shift_q;
               rx_valid_q <= 1'b1;
            end
         end
      end
   end

   assign rx_data      = rx_data_q;
   assign rx_valid     = rx_valid_q;
   assign rx_flag      = rx_flag_q;
   assign parity_error = parity_error_q;
   assign frame_error  = frame_error_q;
   assign busy         = busy_q;

endmodule
